multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 79 +++++++
 rtl/multicycle_ctrl_alu_decoder.sv | 49 ++++
 rtl/multicycle_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared opcode, funct and ALU constants plus FSM state encoding.
// CTRL_JAL_EN adds the JAL state to the state enumeration.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_NOR = 4'hC;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_IEXEC,
    S_IWB,
    S_JUMP
`ifdef CTRL_JAL_EN
    ,
    S_JAL
`endif
  } state_e;

  typedef enum logic [2:0] {
    AOP_ZERO,
    AOP_ADD,
    AOP_SUB,
    AOP_RTYPE,
    AOP_ITYPE
  } aluop_e;

  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_dst;
    logic       ior_d;
    logic       alu_src_a;
    logic       ir_write;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic       branch_ne;
    logic       zero_ext;
    logic       mem_req;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       illegal_op;
    logic       bus_err;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decoder: fixed add/sub, R-type funct or I-type opcode.
// Unknown R-type funct yields AND and flags funct_bad_o.
module alu_decoder
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALUCTL_W = 4
) (
  input  aluop_e              aluop_i,
  input  logic [5:0]          op_i,
  input  logic [5:0]          funct_i,
  output logic [ALUCTL_W-1:0] alu_ctl_o,
  output logic                funct_bad_o
);

  logic [3:0] code;

  always_comb begin
    code        = ALU_AND;
    funct_bad_o = 1'b0;
    unique case (aluop_i)
      AOP_ADD: code = ALU_ADD;
      AOP_SUB: code = ALU_SUB;
      AOP_RTYPE: begin
        unique case (funct_i)
          FN_ADD:  code = ALU_ADD;
          FN_SUB:  code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_XOR:  code = ALU_XOR;
          FN_NOR:  code = ALU_NOR;
          FN_SLT:  code = ALU_SLT;
          default: funct_bad_o = 1'b1;
        endcase
      end
      AOP_ITYPE: begin
        unique case (op_i)
          OP_ADDI: code = ALU_ADD;
          OP_SLTI: code = ALU_SLT;
          OP_ORI:  code = ALU_OR;
          default: code = ALU_AND;
        endcase
      end
      default: code = ALU_AND;
    endcase
  end

  assign alu_ctl_o = ALUCTL_W'(code);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with memory wait timeout.
// Define CTRL_JAL_EN to enable the JAL instruction path.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALUCTL_W = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                mem_ready,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                IorD,
  output logic                ALUSrcA,
  output logic                IRWrite,
  output logic                MemWrite,
  output logic                PCWrite,
  output logic                Branch,
  output logic                RegWrite,
  output logic                BranchNe,
  output logic                ZeroExt,
  output logic                mem_req,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                illegal_op,
  output logic                bus_err
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  aluop_e              aluop;
  logic [ALUCTL_W-1:0] alu_ctl;
  logic                funct_bad;
  logic                timeout;
  ctrl_t               c, ctl;

  alu_decoder #(.ALUCTL_W(ALUCTL_W)) u_alu (
    .aluop_i    (aluop),
    .op_i       (op),
    .funct_i    (funct),
    .alu_ctl_o  (alu_ctl),
    .funct_bad_o(funct_bad)
  );

  always_comb begin
    aluop = AOP_ZERO;
    unique case (state_q)
      S_MEMADR: aluop = AOP_ADD;
      S_EXEC:   aluop = AOP_RTYPE;
      S_BRANCH: aluop = AOP_SUB;
      S_IEXEC:  aluop = AOP_ITYPE;
      default:  aluop = AOP_ZERO;
    endcase
  end

  always_comb begin
    state_d = state_q;
    c       = '0;
    unique case (state_q)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = 2'b01;
        if (mem_ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        unique case (op)
          OP_J:                  state_d = S_JUMP;
          OP_BEQ, OP_BNE:        state_d = S_BRANCH;
          OP_RTYPE:              state_d = S_EXEC;
          OP_LW, OP_SW:          state_d = S_MEMADR;
          OP_ADDI, OP_ANDI,
          OP_ORI, OP_SLTI:       state_d = S_IEXEC;
`ifdef CTRL_JAL_EN
          OP_JAL:                state_d = S_JAL;
`endif
          default: begin
            c.illegal_op = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        state_d     = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        c.ior_d   = 1'b1;
        c.mem_req = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        c.ior_d     = 1'b1;
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        state_d      = S_FETCH;
      end
      S_EXEC: begin
        c.alu_src_a  = 1'b1;
        c.illegal_op = funct_bad;
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
        c.branch_ne = (op == OP_BNE);
        state_d     = S_FETCH;
      end
      S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.zero_ext  = (op == OP_ANDI) || (op == OP_ORI);
        state_d     = S_IWB;
      end
      S_IWB: begin
        c.reg_write = 1'b1;
        c.zero_ext  = (op == OP_ANDI) || (op == OP_ORI);
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef CTRL_JAL_EN
      S_JAL: begin
        c.pc_src     = 2'b10;
        c.pc_write   = 1'b1;
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.mem_to_reg = 1'b1;
        state_d      = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Last permitted wait cycle: abandon the access instead of stalling.
    timeout = c.mem_req && !mem_ready &&
              (cnt_q == CNT_W'(WAIT_MAX - 1));
    if (timeout) begin
      c         = '0;
      c.bus_err = 1'b1;
      state_d   = S_FETCH;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || timeout) begin
      cnt_d = '0;
    end else if (c.mem_req && !mem_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ctl        = c;
    ALUControl = alu_ctl;
    if (!reset) begin
      ctl           = '0;
      ctl.mem_req   = 1'b1;
      ctl.alu_src_b = 2'b01;
      ALUControl    = '0;
    end
  end

  assign MemtoReg   = ctl.mem_to_reg;
  assign RegDst     = ctl.reg_dst;
  assign IorD       = ctl.ior_d;
  assign ALUSrcA    = ctl.alu_src_a;
  assign IRWrite    = ctl.ir_write;
  assign MemWrite   = ctl.mem_write;
  assign PCWrite    = ctl.pc_write;
  assign Branch     = ctl.branch;
  assign RegWrite   = ctl.reg_write;
  assign BranchNe   = ctl.branch_ne;
  assign ZeroExt    = ctl.zero_ext;
  assign mem_req    = ctl.mem_req;
  assign ALUSrcB    = ctl.alu_src_b;
  assign PCSrc      = ctl.pc_src;
  assign illegal_op = ctl.illegal_op;
  assign bus_err    = ctl.bus_err;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed table, corner sequences and
// random instructions against an instruction-level cycle model.
module tb_multicycle_ctrl;

  localparam int WM = 15;

  localparam logic [17:0] M2R  = 18'h20000;
  localparam logic [17:0] RDST = 18'h10000;
  localparam logic [17:0] IORD = 18'h08000;
  localparam logic [17:0] SRCA = 18'h04000;
  localparam logic [17:0] IRW  = 18'h02000;
  localparam logic [17:0] MWR  = 18'h01000;
  localparam logic [17:0] PCW  = 18'h00800;
  localparam logic [17:0] BR   = 18'h00400;
  localparam logic [17:0] RWR  = 18'h00200;
  localparam logic [17:0] BNE  = 18'h00100;
  localparam logic [17:0] ZX   = 18'h00080;
  localparam logic [17:0] MREQ = 18'h00040;
  localparam logic [17:0] SB01 = 18'h00010;
  localparam logic [17:0] SB10 = 18'h00020;
  localparam logic [17:0] SB11 = 18'h00030;
  localparam logic [17:0] PC01 = 18'h00004;
  localparam logic [17:0] PC10 = 18'h00008;
  localparam logic [17:0] ILL  = 18'h00002;
  localparam logic [17:0] BERR = 18'h00001;
  localparam logic [17:0] FRDY = MREQ | SB01 | IRW | PCW;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rdy;
    logic [17:0] ex;
    logic [3:0]  alu;
  } vec_t;

  logic clk = 1'b0;
  logic reset, mem_ready;
  logic [5:0] op, funct;
  logic MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite;
  logic PCWrite, Branch, RegWrite, BranchNe, ZeroExt, mem_req;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUControl;
  logic illegal_op, bus_err;
  logic [17:0] got;

  int total = 0;
  int bad   = 0;

  vec_t q[$];
  vec_t tbl[$];
  logic [5:0] c_op, c_fn;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .mem_ready(mem_ready), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .IorD(IorD), .ALUSrcA(ALUSrcA), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .PCWrite(PCWrite), .Branch(Branch),
    .RegWrite(RegWrite), .BranchNe(BranchNe), .ZeroExt(ZeroExt),
    .mem_req(mem_req), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUControl(ALUControl), .illegal_op(illegal_op),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  assign got = {MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite,
                PCWrite, Branch, RegWrite, BranchNe, ZeroExt, mem_req,
                ALUSrcB, PCSrc, illegal_op, bus_err};

  task automatic check(string nm, logic [17:0] e, logic [3:0] a);
    total++;
    if (got !== e || ALUControl !== a) begin
      bad++;
      $display("FAIL %s t=%0t: got %h alu %h, want %h alu %h",
               nm, $time, got, ALUControl, e, a);
    end
  endtask

  task automatic apply(string nm, vec_t v);
    op = v.op; funct = v.fn; mem_ready = v.rdy;
    #4;
    check(nm, v.ex, v.alu);
    @(posedge clk);
    #1;
  endtask

  task automatic run_q(string nm);
    vec_t v;
    while (q.size() > 0) begin
      v = q.pop_front();
      apply(nm, v);
    end
  endtask

  function automatic vec_t mk(logic [5:0] o, logic [5:0] f, logic r,
                              logic [17:0] e, logic [3:0] a);
    mk = '{op: o, fn: f, rdy: r, ex: e, alu: a};
  endfunction

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic void push(logic r, logic [17:0] e, logic [3:0] a);
    q.push_back(mk(c_op, c_fn, r, e, a));
  endfunction

  // One memory access: w not-ready cycles then a ready one, unless the
  // WM-th not-ready cycle comes first, which is a bus error.
  function automatic bit access(logic [17:0] m, logic [17:0] mr, int w);
    for (int i = 0; i < w; i++) begin
      if (i == WM - 1) begin
        push(1'b0, BERR, 4'h0);
        return 1'b0;
      end
      push(1'b0, m, 4'h0);
    end
    push(1'b1, mr, 4'h0);
    return 1'b1;
  endfunction

  function automatic logic [4:0] rdec(logic [5:0] f);
    case (f)
      6'h20:   return 5'h02;
      6'h22:   return 5'h06;
      6'h24:   return 5'h00;
      6'h25:   return 5'h01;
      6'h26:   return 5'h03;
      6'h27:   return 5'h0C;
      6'h2A:   return 5'h07;
      default: return 5'h10;
    endcase
  endfunction

  // Expected cycle trace of one instruction starting in FETCH.
  function automatic void build(logic [5:0] o, logic [5:0] f,
                                int fw, int mw);
    logic [4:0]  r;
    logic [17:0] m;
    logic [3:0]  a;
    bit jal;
    c_op = o; c_fn = f;
    jal = 1'b0;
`ifdef CTRL_JAL_EN
    jal = 1'b1;
`endif
    if (!access(MREQ | SB01, FRDY, fw)) return;
    case (o)
      6'h02: begin
        push(rnd(), SB11, 4'h0);
        push(rnd(), PC10 | PCW, 4'h0);
      end
      6'h03: begin
        if (jal) begin
          push(rnd(), SB11, 4'h0);
          push(rnd(), PC10 | PCW | RWR | RDST | M2R, 4'h0);
        end else begin
          push(rnd(), SB11 | ILL, 4'h0);
        end
      end
      6'h04, 6'h05: begin
        push(rnd(), SB11, 4'h0);
        push(rnd(), SRCA | PC01 | BR | ((o == 6'h05) ? BNE : 18'h0),
             4'h6);
      end
      6'h00: begin
        r = rdec(f);
        push(rnd(), SB11, 4'h0);
        push(rnd(), SRCA | (r[4] ? ILL : 18'h0), r[3:0]);
        push(rnd(), RDST | RWR, 4'h0);
      end
      6'h23, 6'h2B: begin
        push(rnd(), SB11, 4'h0);
        push(rnd(), SRCA | SB10, 4'h2);
        m = IORD | MREQ | ((o == 6'h2B) ? MWR : 18'h0);
        if (access(m, m, mw) && o == 6'h23) push(rnd(), M2R | RWR, 4'h0);
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        m = (o == 6'h0C || o == 6'h0D) ? ZX : 18'h0;
        a = (o == 6'h08) ? 4'h2 : (o == 6'h0A) ? 4'h7 :
            (o == 6'h0D) ? 4'h1 : 4'h0;
        push(rnd(), SB11, 4'h0);
        push(rnd(), SRCA | SB10 | m, a);
        push(rnd(), RWR | m, 4'h0);
      end
      default: push(rnd(), SB11 | ILL, 4'h0);
    endcase
  endfunction

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 12))
      0:  return 6'h00;
      1:  return 6'h02;
      2:  return 6'h03;
      3:  return 6'h04;
      4:  return 6'h05;
      5:  return 6'h08;
      6:  return 6'h0A;
      7:  return 6'h0C;
      8:  return 6'h0D;
      9:  return 6'h23;
      10: return 6'h2B;
      11: return 6'h00;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] pick_fn();
    case ($urandom_range(0, 7))
      0: return 6'h20;
      1: return 6'h22;
      2: return 6'h24;
      3: return 6'h25;
      4: return 6'h26;
      5: return 6'h27;
      6: return 6'h2A;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic int pick_w();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(13, 17));
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    reset = 1'b0; op = 6'h00; funct = 6'h00; mem_ready = 1'b1;
    #3;
    check("reset_outputs", MREQ | SB01, 4'h0);
    @(posedge clk);
    #1;
    check("reset_after_edge", MREQ | SB01, 4'h0);
    reset = 1'b1;

    // LW with 3 waits, BNE, ORI, op 3F, SUB, bad funct, BEQ
    tbl.push_back(mk(6'h23, 6'h00, 1, FRDY, 4'h0));
    tbl.push_back(mk(6'h23, 6'h00, 1, SB11, 4'h0));
    tbl.push_back(mk(6'h23, 6'h00, 1, SRCA | SB10, 4'h2));
    tbl.push_back(mk(6'h23, 6'h00, 0, IORD | MREQ, 4'h0));
    tbl.push_back(mk(6'h23, 6'h00, 0, IORD | MREQ, 4'h0));
    tbl.push_back(mk(6'h23, 6'h00, 0, IORD | MREQ, 4'h0));
    tbl.push_back(mk(6'h23, 6'h00, 1, IORD | MREQ, 4'h0));
    tbl.push_back(mk(6'h23, 6'h00, 1, M2R | RWR, 4'h0));
    tbl.push_back(mk(6'h05, 6'h00, 0, MREQ | SB01, 4'h0));
    tbl.push_back(mk(6'h05, 6'h00, 1, FRDY, 4'h0));
    tbl.push_back(mk(6'h05, 6'h00, 0, SB11, 4'h0));
    tbl.push_back(mk(6'h05, 6'h00, 1, SRCA | PC01 | BR | BNE, 4'h6));
    tbl.push_back(mk(6'h0D, 6'h00, 1, FRDY, 4'h0));
    tbl.push_back(mk(6'h0D, 6'h00, 0, SB11, 4'h0));
    tbl.push_back(mk(6'h0D, 6'h00, 1, SRCA | SB10 | ZX, 4'h1));
    tbl.push_back(mk(6'h0D, 6'h00, 0, RWR | ZX, 4'h0));
    tbl.push_back(mk(6'h3F, 6'h00, 1, FRDY, 4'h0));
    tbl.push_back(mk(6'h3F, 6'h00, 1, SB11 | ILL, 4'h0));
    tbl.push_back(mk(6'h00, 6'h22, 0, MREQ | SB01, 4'h0));
    tbl.push_back(mk(6'h00, 6'h22, 1, FRDY, 4'h0));
    tbl.push_back(mk(6'h00, 6'h22, 1, SB11, 4'h0));
    tbl.push_back(mk(6'h00, 6'h22, 0, SRCA, 4'h6));
    tbl.push_back(mk(6'h00, 6'h22, 1, RDST | RWR, 4'h0));
    tbl.push_back(mk(6'h00, 6'h15, 1, FRDY, 4'h0));
    tbl.push_back(mk(6'h00, 6'h15, 0, SB11, 4'h0));
    tbl.push_back(mk(6'h00, 6'h15, 1, SRCA | ILL, 4'h0));
    tbl.push_back(mk(6'h00, 6'h15, 0, RDST | RWR, 4'h0));
    tbl.push_back(mk(6'h04, 6'h00, 0, MREQ | SB01, 4'h0));
    tbl.push_back(mk(6'h04, 6'h00, 1, FRDY, 4'h0));
    tbl.push_back(mk(6'h04, 6'h00, 0, SB11, 4'h0));
    tbl.push_back(mk(6'h04, 6'h00, 1, SRCA | PC01 | BR, 4'h6));
    for (int i = 0; i < tbl.size(); i++) apply("table", tbl[i]);

    // SW never ready: bus error on 15th wait, then a clean J from FETCH
    build(6'h2B, 6'h00, 0, 40);
    build(6'h02, 6'h00, 0, 0);
    run_q("sw_bus_err");

    // Wait-count boundaries: 14 waits complete, 15 waits time out
    build(6'h23, 6'h00, 0, 14);
    build(6'h08, 6'h00, 14, 0);
    build(6'h0C, 6'h00, 15, 0);
    build(6'h23, 6'h00, 0, 15);
    run_q("wait_boundary");

    build(6'h03, 6'h00, 0, 0);
    run_q("jal");

    // Reset pulled in the middle of a store wait cycle
    c_op = 6'h2B; c_fn = 6'h00;
    push(1'b1, FRDY, 4'h0);
    push(1'b0, SB11, 4'h0);
    push(1'b1, SRCA | SB10, 4'h2);
    push(1'b0, IORD | MREQ | MWR, 4'h0);
    run_q("memwr_pre");
    mem_ready = 1'b0;
    #2;
    check("memwr_held", IORD | MREQ | MWR, 4'h0);
    reset = 1'b0;
    #1;
    mem_ready = 1'b1;
    #1;
    check("reset_async_drop", MREQ | SB01, 4'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_ready = 1'b0;
    #3;
    check("fetch_after_release", MREQ | SB01, 4'h0);
    @(posedge clk);
    #1;
    build(6'h02, 6'h00, 0, 0);
    run_q("post_reset_j");

    repeat (300) begin
      build(pick_op(), pick_fn(), pick_w(), pick_w());
      run_q("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
